sp_ram_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port RAM (req/gnt/rvalid protocol, byte enables) among NUM_PORTS masters, e.g. instruction fetch and load/store ports of a core. Sits between the masters and the RAM: selects one request per cycle, forwards its address, data and byte enables, and routes each RAM response back to the master that issued it. A small in-order tag FIFO tracks outstanding accesses, so the arbiter tolerates RAM response latencies of 1 to OUTSTANDING cycles.

---
 rtl/sp_ram_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_sp_ram_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter
// Shares one single-port RAM (req/gnt/rvalid handshake with byte enables)
// among NUM_PORTS masters. Each cycle one requesting master is picked in
// round-robin order and its address, write enable, write data and byte
// enables are forwarded to the RAM. The index of every granted master is
// pushed into a small in-order tag FIFO, so each RAM response can be routed
// back to the master that issued the access. Up to OUTSTANDING accesses may
// be in flight, which covers RAM response latencies of 1..OUTSTANDING cycles.
//
// Ports
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   m_req_i         per-master request
//   m_addr_i        per-master address, master k in slice k
//   m_we_i          per-master write enable
//   m_wdata_i       per-master write data, master k in slice k
//   m_be_i          per-master byte enables, master k in slice k
//   m_gnt_o         per-master grant (one-hot or zero)
//   m_rvalid_o      per-master response valid (one-hot or zero)
//   m_rdata_o       read data, shared by all masters
//   ram_req_o       request to the RAM
//   ram_addr_o      forwarded address
//   ram_we_o        forwarded write enable
//   ram_wdata_o     forwarded write data
//   ram_be_o        forwarded byte enables
//   ram_gnt_i       RAM grant
//   ram_rvalid_i    RAM response valid (one per granted access)
//   ram_rdata_i     RAM read data
//   err_o           sticky error: a RAM response arrived with nothing outstanding
module sp_ram_arbiter #(
   parameter int NUM_PORTS   = 2,
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int OUTSTANDING = 2
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [NUM_PORTS-1:0]                  m_req_i,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]       m_addr_i,
   input  logic [NUM_PORTS-1:0]                  m_we_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]       m_wdata_i,
   input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]   m_be_i,
   output logic [NUM_PORTS-1:0]                  m_gnt_o,
   output logic [NUM_PORTS-1:0]                  m_rvalid_o,
   output logic [DATA_WIDTH-1:0]                 m_rdata_o,
   output logic                                  ram_req_o,
   output logic [ADDR_WIDTH-1:0]                 ram_addr_o,
   output logic                                  ram_we_o,
   output logic [DATA_WIDTH-1:0]                 ram_wdata_o,
   output logic [DATA_WIDTH/8-1:0]               ram_be_o,
   input  logic                                  ram_gnt_i,
   input  logic                                  ram_rvalid_i,
   input  logic [DATA_WIDTH-1:0]                 ram_rdata_i,
   output logic                                  err_o
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int PTR_W = $clog2(NUM_PORTS);
   localparam int FP_W  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int DEPTH = 2 ** FP_W;
   localparam int CNT_W = $clog2(OUTSTANDING + 1);

   localparam logic [PTR_W:0]   NP_EXT   = (PTR_W+1)'(NUM_PORTS);
   localparam logic [FP_W-1:0]  FP_LAST  = FP_W'(OUTSTANDING - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);

   logic [PTR_W-1:0]     r_rrPtr;
   logic [PTR_W-1:0]     r_tags [DEPTH];
   logic [FP_W-1:0]      r_wrPtr;
   logic [FP_W-1:0]      r_rdPtr;
   logic [CNT_W-1:0]     r_count;
   logic                 r_err;

   logic [2*NUM_PORTS-1:0] w_reqDbl;
   logic [PTR_W-1:0]       w_offset;
   logic [PTR_W:0]         w_selRaw;
   logic [PTR_W:0]         w_selWrap;
   logic [PTR_W-1:0]       w_selIdx;
   logic [PTR_W:0]         w_nextRaw;
   logic [PTR_W-1:0]       w_nextPtr;
   logic                   w_anyReq;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_issueOk;
   logic                   w_grant;
   logic                   w_pop;
   logic [PTR_W-1:0]       w_headTag;

   // Round-robin pick. The request vector is doubled and shifted down by the
   // priority pointer so the lowest set bit is the first requester at or
   // after r_rrPtr; adding that offset back (mod NUM_PORTS) gives its index.
   // The pointer for the next cycle is the winner plus one, wrapped.
   always_comb begin
      w_reqDbl = {m_req_i, m_req_i} >> r_rrPtr;
      w_offset = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (w_reqDbl[i]) begin
            w_offset = PTR_W'(i);
         end
      end
      w_selRaw  = {1'b0, r_rrPtr} + {1'b0, w_offset};
      w_selWrap = w_selRaw - NP_EXT;
      w_selIdx  = (w_selRaw >= NP_EXT) ? w_selWrap[PTR_W-1:0] : w_selRaw[PTR_W-1:0];
      w_nextRaw = {1'b0, w_selIdx} + (PTR_W+1)'(1);
      w_nextPtr = (w_nextRaw == NP_EXT) ? '0 : w_nextRaw[PTR_W-1:0];
   end

   // Forward the selected master's access fields to the RAM; everything
   // reads as zero when nobody is requesting.
   always_comb begin
      ram_addr_o  = '0;
      ram_we_o    = 1'b0;
      ram_wdata_o = '0;
      ram_be_o    = '0;
      if (w_anyReq) begin
         for (int k = 0; k < NUM_PORTS; k++) begin
            if (w_selIdx == PTR_W'(k)) begin
               ram_addr_o  = m_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
               ram_we_o    = m_we_i[k];
               ram_wdata_o = m_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
               ram_be_o    = m_be_i[k*BE_W +: BE_W];
            end
         end
      end
   end

   // Issue is blocked only when every tag slot is taken and no response
   // arrives this cycle; a response pops the head so the slot can be reused
   // in the same cycle. Request and grant are masked while reset is held.
   always_comb begin
      w_anyReq  = |m_req_i;
      w_full    = (r_count == CNT_FULL);
      w_empty   = (r_count == '0);
      w_pop     = ram_rvalid_i & ~w_empty;
      w_issueOk = ~w_full | ram_rvalid_i;
      ram_req_o = rst_n & w_anyReq & w_issueOk;
      w_grant   = ram_req_o & ram_gnt_i;
      w_headTag = r_tags[r_rdPtr];
   end

   // Per-master grant and response strobes. A response goes to whichever
   // master sits at the head of the tag FIFO, so responses leave in the same
   // order the accesses were granted.
   always_comb begin
      m_gnt_o    = '0;
      m_rvalid_o = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         m_gnt_o[k]    = w_grant & (w_selIdx == PTR_W'(k));
         m_rvalid_o[k] = rst_n & w_pop & (w_headTag == PTR_W'(k));
      end
   end

   assign m_rdata_o = ram_rdata_i;
   assign err_o     = r_err;

   // Tag storage: the granted master's index is written at the tail slot.
   // Stale contents are harmless because r_count guards every read.
   always_ff @(posedge clk) begin
      if (w_grant) begin
         r_tags[r_wrPtr] <= w_selIdx;
      end
   end

   // Control state: priority pointer, FIFO pointers and occupancy, and the
   // sticky error flag. A simultaneous push and pop leaves the count alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rrPtr <= '0;
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_grant) begin
            r_rrPtr <= w_nextPtr;
            r_wrPtr <= (r_wrPtr == FP_LAST) ? '0 : r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= (r_rdPtr == FP_LAST) ? '0 : r_rdPtr + 1'b1;
         end
         if (w_grant && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_grant && w_pop) begin
            r_count <= r_count - 1'b1;
         end
         if (ram_rvalid_i && w_empty) begin
            r_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb_sp_ram_arbiter
// Directed bench for sp_ram_arbiter with two masters, 8-bit addresses,
// 32-bit data and a two-deep tag FIFO. A behavioural RAM with configurable
// latency answers the DUT's forwarded accesses; an independent reference
// memory built from what the masters intended supplies the expected read
// data. Every granted access is pushed to a response queue and popped when
// the matching response is expected back at a master.
module tb_sp_ram_arbiter;

   localparam int NP  = 2;
   localparam int AW  = 8;
   localparam int DW  = 32;
   localparam int BW  = DW / 8;
   localparam int OUT = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NP-1:0]     m_req_i;
   logic [NP*AW-1:0]  m_addr_i;
   logic [NP-1:0]     m_we_i;
   logic [NP*DW-1:0]  m_wdata_i;
   logic [NP*BW-1:0]  m_be_i;
   logic [NP-1:0]     m_gnt_o;
   logic [NP-1:0]     m_rvalid_o;
   logic [DW-1:0]     m_rdata_o;
   logic              ram_req_o;
   logic [AW-1:0]     ram_addr_o;
   logic              ram_we_o;
   logic [DW-1:0]     ram_wdata_o;
   logic [BW-1:0]     ram_be_o;
   logic              ram_gnt_i;
   logic              ram_rvalid_i;
   logic [DW-1:0]     ram_rdata_i;
   logic              err_o;

   sp_ram_arbiter #(
      .NUM_PORTS  (NP),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .OUTSTANDING(OUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .m_req_i     (m_req_i),
      .m_addr_i    (m_addr_i),
      .m_we_i      (m_we_i),
      .m_wdata_i   (m_wdata_i),
      .m_be_i      (m_be_i),
      .m_gnt_o     (m_gnt_o),
      .m_rvalid_o  (m_rvalid_o),
      .m_rdata_o   (m_rdata_o),
      .ram_req_o   (ram_req_o),
      .ram_addr_o  (ram_addr_o),
      .ram_we_o    (ram_we_o),
      .ram_wdata_o (ram_wdata_o),
      .ram_be_o    (ram_be_o),
      .ram_gnt_i   (ram_gnt_i),
      .ram_rvalid_i(ram_rvalid_i),
      .ram_rdata_i (ram_rdata_i),
      .err_o       (err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [BW-1:0] be;
   } txn_t;

   typedef struct {
      int            master;
      logic          isRead;
      logic [DW-1:0] data;
      logic [DW-1:0] expData;
      int            due;
   } resp_t;

   txn_t          mq0[$];
   txn_t          mq1[$];
   resp_t         respQ[$];
   logic [NP-1:0] grantLog[$];
   logic [DW-1:0] ramMem [256];
   logic [DW-1:0] refMem [256];

   int   cycleNum;
   int   latency;
   int   holdRvalid;
   int   rrModel;
   int   stallCount;
   logic errModel;
   bit   injectSpurious;
   int   checkCount;
   int   passCount;
   int   failCount;

   // Bounds the whole run in case the DUT wedges the bench somewhere.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] mergeBe(input logic [DW-1:0] old, input logic [DW-1:0] wdata,
                                             input logic [BW-1:0] be);
      logic [DW-1:0] res;
      res = old;
      for (int b = 0; b < BW; b++) begin
         if (be[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
      end
      return res;
   endfunction

   function automatic bit hasReq(input int m);
      return (m == 0) ? (mq0.size() > 0) : (mq1.size() > 0);
   endfunction

   task automatic driveMasters();
      txn_t t;
      m_req_i   = '0;
      m_addr_i  = '0;
      m_we_i    = '0;
      m_wdata_i = '0;
      m_be_i    = '0;
      if (mq0.size() > 0) begin
         t = mq0[0];
         m_req_i[0] = 1'b1;
         m_we_i[0]  = t.we;
         m_addr_i[AW-1:0]  = t.addr;
         m_wdata_i[DW-1:0] = t.wdata;
         m_be_i[BW-1:0]    = t.be;
      end
      if (mq1.size() > 0) begin
         t = mq1[0];
         m_req_i[1] = 1'b1;
         m_we_i[1]  = t.we;
         m_addr_i[2*AW-1:AW]  = t.addr;
         m_wdata_i[2*DW-1:DW] = t.wdata;
         m_be_i[2*BW-1:BW]    = t.be;
      end
   endtask

   function automatic txn_t mkTxn(input logic we, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] wdata, input logic [BW-1:0] be);
      txn_t t;
      t.we = we; t.addr = addr; t.wdata = wdata; t.be = be;
      return t;
   endfunction

   // One clock cycle: drive masters and the RAM response, check the DUT's
   // combinational outputs at the falling edge, then update the models.
   task automatic applyStimulus();
      logic          rvNow;
      logic          popNow;
      logic          anyReq;
      logic          issueOk;
      logic          expReq;
      logic [NP-1:0] expGnt;
      logic [NP-1:0] expRv;
      logic [DW-1:0] expRdata;
      int            sel;
      txn_t          t;
      resp_t         r;

      driveMasters();
      rvNow = 1'b0;
      if (injectSpurious) rvNow = 1'b1;
      else if (holdRvalid == 0 && respQ.size() > 0 && respQ[0].due <= cycleNum) rvNow = 1'b1;
      ram_rvalid_i = rvNow;
      popNow = rvNow && (respQ.size() > 0);
      ram_rdata_i = popNow ? respQ[0].data : DW'($urandom);

      @(negedge clk);

      expRv    = '0;
      expRdata = ram_rdata_i;
      if (popNow) begin
         expRv[respQ[0].master] = 1'b1;
         if (respQ[0].isRead) expRdata = respQ[0].expData;
      end
      checkOutput("m_rvalid", m_rvalid_o, expRv);
      checkOutput("m_rdata", m_rdata_o, expRdata);
      checkOutput("err_o", err_o, errModel);

      anyReq  = (mq0.size() > 0) || (mq1.size() > 0);
      issueOk = (respQ.size() < OUT) || popNow;
      expReq  = anyReq && issueOk;
      checkOutput("ram_req", ram_req_o, expReq);
      if (m_req_i != '0 && !ram_req_o) stallCount++;

      expGnt = '0;
      sel = -1;
      if (expReq) begin
         for (int i = 0; i < NP; i++) begin
            if (sel < 0 && hasReq((rrModel + i) % NP)) sel = (rrModel + i) % NP;
         end
         expGnt[sel] = 1'b1;
         t = (sel == 0) ? mq0[0] : mq1[0];
         checkOutput("ram_addr", ram_addr_o, t.addr);
         checkOutput("ram_we", ram_we_o, t.we);
         checkOutput("ram_be", ram_be_o, t.be);
         if (t.we) checkOutput("ram_wdata", ram_wdata_o, t.wdata);
      end
      checkOutput("m_gnt", m_gnt_o, expGnt);
      if (m_gnt_o != '0) grantLog.push_back(m_gnt_o);

      if (popNow) void'(respQ.pop_front());
      if (injectSpurious && !popNow) errModel = 1'b1;
      if (expReq) begin
         // RAM side acts on what the DUT forwarded; reference side on intent.
         if (ram_we_o) ramMem[ram_addr_o] = mergeBe(ramMem[ram_addr_o], ram_wdata_o, ram_be_o);
         r.data = ram_we_o ? DW'($urandom) : ramMem[ram_addr_o];
         if (t.we) refMem[t.addr] = mergeBe(refMem[t.addr], t.wdata, t.be);
         r.expData = refMem[t.addr];
         r.master  = sel;
         r.isRead  = !t.we;
         r.due     = cycleNum + latency;
         respQ.push_back(r);
         if (sel == 0) void'(mq0.pop_front());
         else          void'(mq1.pop_front());
         rrModel = (sel + 1) % NP;
      end
      if (holdRvalid > 0) holdRvalid--;

      @(posedge clk);
      #1;
      cycleNum++;
   endtask

   task automatic runUntilIdle(input string tag, input int maxCycles);
      int n;
      n = 0;
      while ((mq0.size() > 0 || mq1.size() > 0 || respQ.size() > 0) && n < maxCycles) begin
         applyStimulus();
         n++;
      end
      checkOutput(tag, mq0.size() + mq1.size() + respQ.size(), 0);
   endtask

   task automatic checkAlternating(input string tag, input int expCount);
      checkOutput({tag, "_count"}, grantLog.size(), expCount);
      for (int i = 0; i < grantLog.size() && i < expCount; i++) begin
         checkOutput($sformatf("%s_%0d", tag, i), grantLog[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      end
   endtask

   initial begin
      checkCount = 0; passCount = 0; failCount = 0;
      cycleNum = 0; latency = 1; holdRvalid = 0; rrModel = 0;
      errModel = 1'b0; injectSpurious = 1'b0; stallCount = 0;
      for (int a = 0; a < 256; a++) begin
         ramMem[a] = {8'(a), ~8'(a), 8'(a) ^ 8'h5A, 8'hC3};
         refMem[a] = ramMem[a];
      end

      // Reset held with both masters requesting: nothing may be granted.
      $display("[TB] reset with both masters requesting");
      rst_n        = 1'b0;
      ram_gnt_i    = 1'b1;
      ram_rvalid_i = 1'b0;
      ram_rdata_i  = '0;
      for (int i = 0; i < 3; i++) begin
         mq0.push_back(mkTxn(1'b0, 8'h20 + 8'(4*i), '0, 4'hF));
         mq1.push_back(mkTxn(1'b0, 8'h80 + 8'(4*i), '0, 4'hF));
      end
      driveMasters();
      @(negedge clk);
      checkOutput("rst_gnt", m_gnt_o, 2'b00);
      checkOutput("rst_ram_req", ram_req_o, 1'b0);
      checkOutput("rst_err", err_o, 1'b0);
      checkOutput("rst_rvalid", m_rvalid_o, 2'b00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Contention with a latency-1 RAM: grants alternate starting at 0.
      $display("[TB] contention, latency 1");
      grantLog.delete();
      runUntilIdle("contention_drain", 20);
      checkAlternating("contention_order", 6);

      // Single master: four partial writes then four reads, one per cycle.
      $display("[TB] single master writes and reads");
      for (int i = 0; i < 4; i++)
         mq1.push_back(mkTxn(1'b1, 8'h10 + 8'(4*i), 32'hBEEF_0000 + 32'(i * 32'h1111), 4'b0011));
      for (int i = 0; i < 4; i++)
         mq1.push_back(mkTxn(1'b0, 8'h10 + 8'(4*i), '0, 4'hF));
      grantLog.delete();
      for (int i = 0; i < 8; i++) applyStimulus();
      checkOutput("single_grants", grantLog.size(), 8);
      runUntilIdle("single_drain", 10);

      // Latency-2 RAM: FIFO fills to two, responses return in grant order.
      $display("[TB] contention, latency 2");
      latency = 2;
      for (int i = 0; i < 4; i++) begin
         mq0.push_back(mkTxn(1'b0, 8'h40 + 8'(4*i), '0, 4'hF));
         mq1.push_back(mkTxn(1'b0, 8'hC0 + 8'(4*i), '0, 4'hF));
      end
      grantLog.delete();
      runUntilIdle("lat2_drain", 40);
      checkAlternating("lat2_order", 8);

      // FIFO full stall: RAM sits on responses, issue stops after two grants.
      $display("[TB] fifo full stall");
      latency    = 1;
      holdRvalid = 4;
      stallCount = 0;
      for (int i = 0; i < 4; i++)
         mq0.push_back(mkTxn(1'b0, 8'h60 + 8'(4*i), '0, 4'hF));
      runUntilIdle("stall_drain", 30);
      checkOutput("stall_cycles", stallCount, 2);

      // Response with nothing outstanding sets a sticky error.
      $display("[TB] spurious response");
      injectSpurious = 1'b1;
      applyStimulus();
      injectSpurious = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus();

      // Reset clears the error immediately and masks a pending request.
      mq0.push_back(mkTxn(1'b0, 8'h04, '0, 4'hF));
      driveMasters();
      rst_n = 1'b0;
      #1;
      checkOutput("rst2_err", err_o, 1'b0);
      checkOutput("rst2_ram_req", ram_req_o, 1'b0);
      checkOutput("rst2_gnt", m_gnt_o, 2'b00);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
